// File: rtl/input_route_buffer.sv
// Per-input-port flit FIFO with XY route computation on the head flit and a
// request/grant handshake toward the conflict judge. Optional starvation
// counter under INPUT_ROUTE_BUFFER_STARVE_EN.
module input_route_buffer #(
  parameter int DATA_W  = 16,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
  ,
  parameter int STARVE_TH = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [1:0]               dout,
  input  logic                     fail,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_dir,
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
  output logic [3:0]               retry_cnt,
  output logic                     starve,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RC, S_REQ} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_count;
  logic [1:0]          r_dir_q;
  logic                w_wr, w_pop;
  logic [DATA_W-1:0]   w_head;
  logic [COORD_W-1:0]  w_dst_x, w_dst_y;
  logic [1:0]          w_route;

  assign in_ready = (r_count < (AW+1)'(DEPTH));
  assign w_wr     = in_valid && in_ready;
  assign w_pop    = (r_state == S_REQ) && enable && !fail;
  assign count    = r_count;

  assign w_head  = r_mem[r_rptr];
  assign w_dst_x = w_head[DATA_W-1 -: COORD_W];
  assign w_dst_y = w_head[DATA_W-1-COORD_W -: COORD_W];

  always_comb begin
    w_route = 2'b11;
    if (w_dst_x != COORD_W'(X_ID))      w_route = 2'b01;
    else if (w_dst_y != COORD_W'(Y_ID)) w_route = 2'b10;
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A same-edge write counts toward the post-pop occupancy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_RC;
      S_RC:    w_state_nxt = S_REQ;
      S_REQ:   if (w_pop) w_state_nxt = ((r_count > (AW+1)'(1)) || w_wr) ? S_RC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // dout depends only on registered state so fail cannot loop back.
  assign dout = (r_state == S_REQ) ? r_dir_q : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_q   <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dir   <= 2'b00;
    end else begin
      if (r_state == S_RC) r_dir_q <= w_route;
      out_valid <= w_pop;
      if (w_pop) begin
        out_data <= w_head;
        out_dir  <= r_dir_q;
      end
    end
  end

`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
  logic [3:0] r_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_retry <= 4'd0;
    else if (w_pop)                                  r_retry <= 4'd0;
    else if ((r_state == S_REQ) && enable && fail &&
             (r_retry != 4'd15))                     r_retry <= r_retry + 4'd1;
  end

  assign retry_cnt = r_retry;
  assign starve    = (32'(r_retry) >= STARVE_TH);
`endif

endmodule

// File: tb/tb_input_route_buffer.sv
// Directed self-checking bench for input_route_buffer (X_ID=1, Y_ID=1, DEPTH=4).
module tb_input_route_buffer;
  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, fail;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [1:0]  dout, out_dir;
  logic [15:0] out_data;
  logic [2:0]  count;
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
  logic [3:0]  retry_cnt;
  logic        starve;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_route_buffer #(.DATA_W(16), .COORD_W(2), .DEPTH(4), .X_ID(1), .Y_ID(1)
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
    , .STARVE_TH(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .dout(dout), .fail(fail),
    .out_valid(out_valid), .out_data(out_data), .out_dir(out_dir),
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
    .retry_cnt(retry_cnt), .starve(starve),
`endif
    .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  logic [15:0] exp_data [9];
  logic [1:0]  exp_dir  [9];
  logic [15:0] new_data [6];
  int          npop;

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; fail = 1'b0; in_data = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_dir", 32'(out_dir), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_starve", 32'(starve), 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // 1: reset mid-operation with two flits queued
    enable = 1'b1; fail = 1'b1;
    put(16'h2ABC);
    put(16'h6000);
    step();
    check("t1_queued", 32'(count), 2);
    check("t1_req", 32'(dout), 1);
    rst_n = 1'b0;
    #2;
    check("t1_async_count", 32'(count), 0);
    check("t1_async_dout", 32'(dout), 0);
    check("t1_async_ovalid", 32'(out_valid), 0);
    check("t1_async_ready", 32'(in_ready), 1);
    step();
    rst_n = 1'b1;
    fail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_no_pop", 32'(out_valid), 0);
      check("t1_stay_empty", 32'(count), 0);
    end

    // 2: X route
    put(16'h2ABC);
    check("t2_count", 32'(count), 1);
    check("t2_dout_e0", 32'(dout), 0);
    step();
    check("t2_dout_e1", 32'(dout), 0);
    step();
    check("t2_dout_e2", 32'(dout), 1);
    step();
    check("t2_ovalid", 32'(out_valid), 1);
    check("t2_odata", 32'(out_data), 'h2ABC);
    check("t2_odir", 32'(out_dir), 1);
    check("t2_dout_after", 32'(dout), 0);
    check("t2_count_after", 32'(count), 0);
    step();
    check("t2_ovalid_pulse", 32'(out_valid), 0);
    check("t2_odata_hold", 32'(out_data), 'h2ABC);

    // 3: Y then LOCAL
    put(16'h6000);
    put(16'h5000);
    step();
    check("t3_dout_y", 32'(dout), 2);
    step();
    check("t3_ovalid_y", 32'(out_valid), 1);
    check("t3_odata_y", 32'(out_data), 'h6000);
    check("t3_odir_y", 32'(out_dir), 2);
    check("t3_dout_gap", 32'(dout), 0);
    step();
    check("t3_dout_local", 32'(dout), 3);
    step();
    check("t3_ovalid_l", 32'(out_valid), 1);
    check("t3_odata_l", 32'(out_data), 'h5000);
    check("t3_odir_l", 32'(out_dir), 3);
    step();

    // 4: fail holds the request; starvation counter if built
    fail = 1'b1;
    put(16'h2ABC);
    step();
    step();
    check("t4_dout", 32'(dout), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t4_hold_dout", 32'(dout), 1);
      check("t4_hold_count", 32'(count), 1);
      check("t4_hold_ovalid", 32'(out_valid), 0);
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
      check("t4_retry", 32'(retry_cnt), 32'(k));
      check("t4_starve", 32'(starve), (k >= 4) ? 1 : 0);
`endif
    end
    fail = 1'b0;
    step();
    check("t4_grant_ovalid", 32'(out_valid), 1);
    check("t4_grant_odata", 32'(out_data), 'h2ABC);
    check("t4_grant_count", 32'(count), 0);
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
    check("t4_retry_clr", 32'(retry_cnt), 0);
    check("t4_starve_clr", 32'(starve), 0);
`endif
    enable = 1'b0;
    put(16'h0123);
    step();
    step();
    check("t4b_dout", 32'(dout), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4b_no_pop", 32'(out_valid), 0);
      check("t4b_count", 32'(count), 1);
`ifdef INPUT_ROUTE_BUFFER_STARVE_EN
      check("t4b_retry", 32'(retry_cnt), 0);
`endif
    end
    enable = 1'b1;
    step();
    check("t4b_grant", 32'(out_valid), 1);
    check("t4b_odata", 32'(out_data), 'h0123);
    step();

    // 5: full, no bypass, pointer wrap
    fail = 1'b1;
    put(16'h0001);
    put(16'h4002);
    put(16'h5003);
    put(16'hC004);
    check("t5_full_count", 32'(count), 4);
    check("t5_full_ready", 32'(in_ready), 0);
    put(16'hFFFF);
    check("t5_overflow", 32'(count), 4);
    in_valid = 1'b1; in_data = 16'hFFFF; fail = 1'b0;
    step();
    in_valid = 1'b0;
    check("t5_grant0", 32'(out_valid), 1);
    check("t5_grant0_data", 32'(out_data), 'h0001);
    check("t5_grant0_dir", 32'(out_dir), 1);
    check("t5_no_bypass", 32'(count), 3);
    check("t5_ready_again", 32'(in_ready), 1);

    exp_data = '{16'h4002, 16'h5003, 16'hC004, 16'h1005, 16'h6006,
                 16'h5007, 16'h8008, 16'h4009, 16'h500A};
    exp_dir  = '{2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    new_data = '{16'h1005, 16'h6006, 16'h5007, 16'h8008, 16'h4009, 16'h500A};
    npop = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = new_data[i];
      for (int s = 0; s < 2; s++) begin
        step();
        in_valid = 1'b0;
        if (out_valid === 1'b1) begin
          if (npop < 9) begin
            check("t5_order_data", 32'(out_data), 32'(exp_data[npop]));
            check("t5_order_dir", 32'(out_dir), 32'(exp_dir[npop]));
          end
          npop++;
        end
      end
    end
    for (int s = 0; s < 40 && npop < 9; s++) begin
      step();
      if (out_valid === 1'b1) begin
        check("t5_order_data", 32'(out_data), 32'(exp_data[npop]));
        check("t5_order_dir", 32'(out_dir), 32'(exp_dir[npop]));
        npop++;
      end
    end
    check("t5_pop_total", 32'(npop), 9);
    step();
    check("t5_drained", 32'(count), 0);
    check("t5_idle_dout", 32'(dout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
